// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci burst collector.
package fib_pkg;

    // fib_in cycles thrown away after the restart pulse (the generator's duplicate 0).
    localparam int unsigned ALIGN_CYCLES = 1;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StAlign,
        StStream,
        StWait
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fib_collect_fifo.sv
// Synchronous FIFO of collector entries; a push is accepted while full when a pop frees the slot.
module fib_collect_fifo #(
    parameter int unsigned EntryW = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [EntryW-1:0] din_i,
    input  logic              pop_i,
    output logic [EntryW-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [EntryW-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign dout_o  = mem_q[rd_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

endmodule

// File: rtl/fib_burst_collector.sv
// Restarts a free-running Fibonacci generator, collects N tagged terms and replays after backpressure.
// Optional replay counter output enabled by FIB_COLLECT_STATS_EN.
module fib_burst_collector
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_count,
    output logic             gen_start,
    input  logic [WIDTH-1:0] fib_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_index,
    output logic             out_last,
    output logic             out_ovf,
    output logic             busy
`ifdef FIB_COLLECT_STATS_EN
    ,
    output logic [7:0]       replay_cnt
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] index;
        logic             last;
        logic             ovf;
    } entry_t;

    localparam int unsigned EntryW = $bits(entry_t);

    state_e           state_q, state_d;
    logic             en_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] next_idx_q, next_idx_d;
    logic [CNT_W-1:0] cur_idx_q, cur_idx_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             ovf_run_q, ovf_run_d;
    logic [1:0]       align_q, align_d;

    logic             fifo_full, fifo_empty, push, pop, full_eff;
    logic             req_fire, wrap, is_last;
    entry_t           push_ent, head_ent;
    logic [EntryW-1:0] head_raw;

`ifdef FIB_COLLECT_STATS_EN
    logic [7:0] replay_q, replay_d;
    assign replay_cnt = replay_q;
`endif

    // en_q keeps req_ready low while reset is asserted.
    assign req_ready = en_q & (state_q == StIdle) & fifo_empty;
    assign req_fire  = req_valid & req_ready;
    assign busy      = (state_q != StIdle) | ~fifo_empty;

    assign pop      = out_valid & out_ready;
    assign full_eff = fifo_full & ~pop;
    assign wrap     = (cur_idx_q >= CNT_W'(2)) && (fib_in < prev_q);
    assign is_last  = (cur_idx_q == CNT_W'(count_q - CNT_W'(1)));

    assign push_ent.data  = fib_in;
    assign push_ent.index = cur_idx_q;
    assign push_ent.last  = is_last;
    assign push_ent.ovf   = ovf_run_q | wrap;

    assign head_ent  = entry_t'(head_raw);
    assign out_valid = ~fifo_empty;
    assign out_data  = out_valid ? head_ent.data  : '0;
    assign out_index = out_valid ? head_ent.index : '0;
    assign out_last  = out_valid & head_ent.last;
    assign out_ovf   = out_valid & head_ent.ovf;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        next_idx_d = next_idx_q;
        cur_idx_d  = cur_idx_q;
        prev_d     = prev_q;
        ovf_run_d  = ovf_run_q;
        align_d    = align_q;
        push       = 1'b0;
        gen_start  = 1'b0;
`ifdef FIB_COLLECT_STATS_EN
        replay_d   = replay_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
`ifdef FIB_COLLECT_STATS_EN
                    replay_d = '0;
`endif
                    if (req_count != '0) begin
                        count_d    = req_count;
                        next_idx_d = '0;
                        state_d    = StLaunch;
                    end
                end
            end
            StLaunch: begin
                gen_start = 1'b1;
                cur_idx_d = '0;
                ovf_run_d = 1'b0;
                align_d   = '0;
                state_d   = StAlign;
            end
            StAlign: begin
                if (align_q == 2'(ALIGN_CYCLES - 1)) begin
                    state_d = StStream;
                end else begin
                    align_d = align_q + 2'd1;
                end
            end
            StStream: begin
                // Index and wrap tracking advance on skipped terms too.
                cur_idx_d = cur_idx_q + CNT_W'(1);
                prev_d    = fib_in;
                ovf_run_d = ovf_run_q | wrap;
                if (cur_idx_q == next_idx_q) begin
                    if (!full_eff) begin
                        push       = 1'b1;
                        next_idx_d = next_idx_q + CNT_W'(1);
                        if (is_last) begin
                            state_d = StIdle;
                        end
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (fifo_empty) begin
                    state_d = StLaunch;
`ifdef FIB_COLLECT_STATS_EN
                    replay_d = sat_inc8(replay_q);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            en_q       <= 1'b0;
            count_q    <= '0;
            next_idx_q <= '0;
            cur_idx_q  <= '0;
            prev_q     <= '0;
            ovf_run_q  <= 1'b0;
            align_q    <= '0;
`ifdef FIB_COLLECT_STATS_EN
            replay_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            en_q       <= 1'b1;
            count_q    <= count_d;
            next_idx_q <= next_idx_d;
            cur_idx_q  <= cur_idx_d;
            prev_q     <= prev_d;
            ovf_run_q  <= ovf_run_d;
            align_q    <= align_d;
`ifdef FIB_COLLECT_STATS_EN
            replay_q   <= replay_d;
`endif
        end
    end

    fib_collect_fifo #(
        .EntryW (EntryW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .din_i   (push_ent),
        .pop_i   (pop),
        .dout_o  (head_raw),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_fib_burst_collector.sv
// Directed bench: generator model, output monitor and linear test sequence for fib_burst_collector.
module tb_fib_burst_collector;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_count;
    logic        gen_start;
    logic [15:0] fib_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_index;
    logic        out_last;
    logic        out_ovf;
    logic        busy;
`ifdef FIB_COLLECT_STATS_EN
    logic [7:0]  replay_cnt;
`endif

    int checks = 0;
    int failures = 0;

    fib_burst_collector #(
        .WIDTH (16),
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_count  (req_count),
        .gen_start  (gen_start),
        .fib_in     (fib_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .out_ovf    (out_ovf),
        .busy       (busy)
`ifdef FIB_COLLECT_STATS_EN
        ,
        .replay_cnt (replay_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator: restart gives a duplicate 0, then F(0), F(1), ...
    logic [15:0] ga, gb;
    logic        gdup;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ga <= 16'd0; gb <= 16'd1; gdup <= 1'b0;
        end else if (gen_start) begin
            ga <= 16'd0; gb <= 16'd1; gdup <= 1'b1;
        end else if (gdup) begin
            gdup <= 1'b0;
        end else begin
            ga <= gb; gb <= ga + gb;
        end
    end
    assign fib_in = ga;

    logic tog, tog_en, rdy_drv;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tog <= 1'b0;
        else        tog <= ~tog;
    end
    assign out_ready = tog_en ? tog : rdy_drv;

    typedef struct {
        int unsigned data;
        int unsigned idx;
        bit          last;
        bit          ovf;
    } rec_t;
    rec_t q[$];
    int gen_cnt = 0;
    int valid_cyc = 0;
    int busy_cyc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (gen_start) gen_cnt++;
            if (out_valid) valid_cyc++;
            if (busy) busy_cyc++;
            if (out_valid && out_ready)
                q.push_back('{out_data, out_index, out_last, out_ovf});
        end
    end

    function automatic int unsigned fib16(input int n);
        logic [15:0] a, b, t;
        a = 16'd0; b = 16'd1;
        for (int i = 0; i < n; i++) begin
            t = a + b; a = b; b = t;
        end
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic run_req(input int cnt);
        int k;
        k = 0;
        while (!req_ready && k < 100) begin
            step(1);
            k++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_count = 8'(cnt);
        step(1);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    // Checks the n records starting at base: full ordered sequence, flags per index.
    task automatic check_burst(input string tag, input int base, input int n, input int wrap_at);
        chk({tag, "_len"}, q.size() - base, n);
        for (int i = 0; i < n && base + i < q.size(); i++) begin
            chk({tag, "_data"}, q[base+i].data, fib16(i));
            chk({tag, "_idx"}, q[base+i].idx, i);
            chk({tag, "_last"}, {31'd0, q[base+i].last}, {31'd0, (i == n - 1)});
            chk({tag, "_ovf"}, {31'd0, q[base+i].ovf}, {31'd0, (i >= wrap_at)});
        end
    endtask

    int base, g0, v0, b0;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_count = 8'd0; rdy_drv = 1'b1; tog_en = 1'b0;
        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_gen_start", {31'd0, gen_start}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // Basic burst of 5 with first-word latency.
        base = q.size(); g0 = gen_cnt;
        run_req(5);
        chk("t1_gen_start", {31'd0, gen_start}, 32'd1);
        chk("t1_req_ready_busy", {31'd0, req_ready}, 32'd0);
        step(1);
        chk("t1_lat_align", {31'd0, out_valid}, 32'd0);
        step(1);
        chk("t1_lat_push", {31'd0, out_valid}, 32'd0);
        step(1);
        chk("t1_lat_visible", {31'd0, out_valid}, 32'd1);
        chk("t1_first_idx", {24'd0, out_index}, 32'd0);
        wait_done("t1_done", 100);
        check_burst("t1", base, 5, 1000);
        chk("t1_gen_pulses", gen_cnt - g0, 1);

        // Backpressure for 30 cycles forces one replay.
        base = q.size(); g0 = gen_cnt;
        rdy_drv = 1'b0;
        run_req(10);
        step(30);
        chk("t2_busy_stalled", {31'd0, busy}, 32'd1);
        chk("t2_head_idx", {24'd0, out_index}, 32'd0);
        rdy_drv = 1'b1;
        wait_done("t2_done", 300);
        check_burst("t2", base, 10, 1000);
        chk("t2_gen_pulses", gen_cnt - g0, 2);
`ifdef FIB_COLLECT_STATS_EN
        chk("t2_replay_cnt", {24'd0, replay_cnt}, 32'd1);
`endif

        // Wrap at WIDTH=16: F(24)=46368, F(25)=75025 mod 65536=9489.
        base = q.size();
        run_req(26);
        wait_done("t3_done", 300);
        check_burst("t3", base, 26, 25);
        if (q.size() >= base + 26) begin
            chk("t3_idx24_data", q[base+24].data, 46368);
            chk("t3_idx25_data", q[base+25].data, 9489);
            chk("t3_idx25_ovf", {31'd0, q[base+25].ovf}, 32'd1);
        end else begin
            chk("t3_short", q.size() - base, 26);
        end

        // count=0 is a no-op handshake.
        step(2);
        g0 = gen_cnt; v0 = valid_cyc; b0 = busy_cyc;
        chk("t4_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_count = 8'd0;
        step(1);
        chk("t4_still_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b0;
        step(8);
        chk("t4_no_gen_start", gen_cnt - g0, 0);
        chk("t4_no_valid", valid_cyc - v0, 0);
        chk("t4_no_busy", busy_cyc - b0, 0);

        // Reset mid-burst drops it; a fresh request starts clean.
        run_req(20);
        step(8);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_data", {16'd0, out_data}, 32'd0);
        chk("t5_rst_index", {24'd0, out_index}, 32'd0);
        chk("t5_rst_last", {31'd0, out_last}, 32'd0);
        chk("t5_rst_ovf", {31'd0, out_ovf}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_ready", {31'd0, req_ready}, 32'd0);
        chk("t5_rst_gen", {31'd0, gen_start}, 32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);
        base = q.size();
        run_req(3);
        wait_done("t5_done", 100);
        check_burst("t5", base, 3, 1000);

        // Toggling out_ready: repeated replays, then across the wrap point.
        tog_en = 1'b1;
        base = q.size();
        run_req(8);
        wait_done("t6_done", 1000);
        check_burst("t6", base, 8, 1000);

        base = q.size(); g0 = gen_cnt;
        run_req(30);
        wait_done("t7_done", 5000);
        check_burst("t7", base, 30, 25);
        chk("t7_replayed", {31'd0, (gen_cnt - g0) >= 2}, 32'd1);
`ifdef FIB_COLLECT_STATS_EN
        chk("t7_replay_cnt", {31'd0, replay_cnt >= 8'd1}, 32'd1);
`endif
        tog_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
